wired_div_ctrl: RTL and testbench

Issue and completion controller for the 64-bit fixed-cycle integer divider. It accepts DIV/DIVU/REM/REMU requests from the ALU issue stage in both 64-bit and 32-bit word forms. It normalises operands, starts the divider, waits out its fixed iteration count and returns a formatted, tagged result over a valid/ready response channel. Divide-by-zero is resolved locally without occupying the divider.

---
 rtl/wired_div_pkg.sv | 28 ++
 rtl/wired_div_fmt.sv | 42 ++++
 rtl/wired_div_ctrl.sv | 120 ++++++++++++
 tb/tb_wired_div_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_div_pkg.sv
// Shared types and constants for the fixed-cycle divider controller.
package wired_div_pkg;

   localparam int DIV_ITER = 64;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } div_state_e;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/wired_div_fmt.sv
// Operand normalisation, zero-divisor detection and result select/format,
// shared by the divide-by-zero bypass and the divider capture path.
module wired_div_fmt
   import wired_div_pkg::*;
(
   input  logic [1:0]  op,
   input  logic        word,
   input  logic        bypass,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [63:0] quo,
   input  logic [63:0] rem,
   output logic [63:0] norm_a,
   output logic [63:0] norm_b,
   output logic        b_zero,
   output logic [63:0] result
);

   div_op_e     op_e;
   logic        sgn;
   logic [63:0] sel;

   // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
   always_comb begin
      op_e   = div_op_e'(op);
      sgn    = op_is_signed(op_e);
      norm_a = a;
      norm_b = b;
      if (word) begin
         norm_a = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
         norm_b = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
      end
      b_zero = (norm_b == 64'd0);

      // Divide-by-zero: quotient is all-ones, remainder is the dividend.
      if (bypass) sel = op_is_rem(op_e) ? norm_a : '1;
      else        sel = op_is_rem(op_e) ? rem : quo;

      result = word ? {{32{sel[31]}}, sel[31:0]} : sel;
   end

endmodule

// File: rtl/wired_div_ctrl.sv
// Issue/completion FSM for the 64-cycle divider: accepts a request, starts the
// divider (or resolves divide-by-zero locally) and holds a tagged response.
module wired_div_ctrl
   import wired_div_pkg::*;
#(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic             req_word,
   input  logic [63:0]      req_a,
   input  logic [63:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             div_start,
   output logic             div_sign,
   output logic [63:0]      div_a,
   output logic [63:0]      div_b,
   input  logic             div_busy,
   input  logic [63:0]      div_quo,
   input  logic [63:0]      div_rem
);

   div_state_e       state, state_nxt;
   div_op_e          op_q;
   logic             word_q;
   logic [TAG_W-1:0] tag_q;
   logic [63:0]      a_q, b_q, data_q;

   logic             in_idle, accept, capture;
   logic [1:0]       fmt_op;
   logic             fmt_word;
   logic [63:0]      norm_a, norm_b, fmt_result;
   logic             b_zero;

   assign in_idle  = (state == IDLE);
   assign fmt_op   = in_idle ? req_op   : op_q;
   assign fmt_word = in_idle ? req_word : word_q;

   // In IDLE the formatter sees the incoming request (bypass); afterwards the latched op.
   wired_div_fmt u_fmt (
      .op     (fmt_op),
      .word   (fmt_word),
      .bypass (in_idle),
      .a      (req_a),
      .b      (req_b),
      .quo    (div_quo),
      .rem    (div_rem),
      .norm_a (norm_a),
      .norm_b (norm_b),
      .b_zero (b_zero),
      .result (fmt_result)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            accept    = 1'b1;
            capture   = b_zero;
            state_nxt = b_zero ? DONE : ISSUE;
         end
         ISSUE: state_nxt = WAIT;
         WAIT: if (!div_busy) begin
            capture   = 1'b1;
            state_nxt = DONE;
         end
         DONE: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Flush wins over everything, including a handshake in DONE.
      if (flush) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         capture   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         data_q <= 64'd0;
         tag_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept)  tag_q  <= req_tag;
         if (capture) data_q <= fmt_result;
      end
   end

   // NOTE: operand registers are not reset; they are always loaded on accept before being used.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= div_op_e'(req_op);
         word_q <= req_word;
         a_q    <= norm_a;
         b_q    <= norm_b;
      end
   end

   assign req_ready  = in_idle && rst_n;
   assign resp_valid = (state == DONE);
   assign resp_data  = data_q;
   assign resp_tag   = tag_q;
   assign div_start  = (state == ISSUE) && !flush;
   assign div_sign   = op_is_signed(op_q);
   assign div_a      = a_q;
   assign div_b      = b_q;

endmodule

// File: tb/tb_wired_div_ctrl.sv
// Self-checking bench for wired_div_ctrl with a behavioural 64-cycle divider
// beside it and an arithmetic reference model for expected results.
module tb_wired_div_ctrl;
   import wired_div_pkg::*;

   localparam int TAG_W   = 6;
   localparam int LAT_DIV = 67;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'd0;
   logic             req_word = 1'b0;
   logic [63:0]      req_a = 64'd0, req_b = 64'd0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [63:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             div_start, div_sign;
   logic [63:0]      div_a, div_b;
   logic             div_busy = 1'b0;
   logic [63:0]      div_quo = 64'd0, div_rem = 64'd0;

   int total = 0;
   int bad = 0;
   int starts = 0;
   int start_base = 0;

   always #5 clk = ~clk;

   wired_div_ctrl #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
      .div_start(div_start), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
      .div_busy(div_busy), .div_quo(div_quo), .div_rem(div_rem)
   );

   // ---------------- arithmetic reference ----------------
   function automatic logic [63:0] mag(input logic [63:0] v, input bit sgn);
      return (sgn && v[63]) ? -v : v;
   endfunction

   function automatic logic [63:0] ref_quo(input logic [63:0] a, input logic [63:0] b, input bit sgn);
      logic [63:0] q;
      q = mag(a, sgn) / mag(b, sgn);
      return (sgn && (a[63] ^ b[63])) ? -q : q;
   endfunction

   function automatic logic [63:0] ref_rem(input logic [63:0] a, input logic [63:0] b, input bit sgn);
      logic [63:0] r;
      r = mag(a, sgn) % mag(b, sgn);
      return (sgn && a[63]) ? -r : r;
   endfunction

   function automatic logic [63:0] sext32(input logic [63:0] v);
      return {{32{v[31]}}, v[31:0]};
   endfunction

   function automatic bit exp_zero(input logic word, input logic [63:0] b);
      return word ? (b[31:0] == 32'd0) : (b == 64'd0);
   endfunction

   function automatic logic [63:0] exp_result(input logic [1:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
      bit          sgn, is_rem;
      logic [63:0] na, nb, r;
      sgn    = (op == 2'd0) || (op == 2'd2);
      is_rem = (op == 2'd2) || (op == 2'd3);
      na = a;
      nb = b;
      if (word) begin
         na = sgn ? sext32(a) : {32'd0, a[31:0]};
         nb = sgn ? sext32(b) : {32'd0, b[31:0]};
      end
      if (nb == 64'd0) r = is_rem ? na : 64'hFFFF_FFFF_FFFF_FFFF;
      else             r = is_rem ? ref_rem(na, nb, sgn) : ref_quo(na, nb, sgn);
      return word ? sext32(r) : r;
   endfunction

   // ---------------- behavioural divider ----------------
   int          dv_cnt = 0;
   logic [63:0] pend_quo = 64'd0, pend_rem = 64'd0;

   always @(posedge clk) begin
      if (div_start) begin
         starts   <= starts + 1;
         div_busy <= 1'b1;
         dv_cnt   <= DIV_ITER;
         pend_quo <= ref_quo(div_a, div_b, div_sign);
         pend_rem <= ref_rem(div_a, div_b, div_sign);
         div_quo  <= {$urandom, $urandom};
         div_rem  <= {$urandom, $urandom};
      end else if (div_busy) begin
         dv_cnt <= dv_cnt - 1;
         if (dv_cnt == 1) begin
            div_busy <= 1'b0;
            div_quo  <= pend_quo;
            div_rem  <= pend_rem;
         end else begin
            div_quo <= {$urandom, $urandom};
            div_rem <= {$urandom, $urandom};
         end
      end
   end

   // ---------------- checking and stimulus tasks ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] tag);
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         check("ready_timeout", req_ready, 1);
         return;
      end
      req_op = op; req_word = word; req_a = a; req_b = b; req_tag = tag;
      req_valid = 1'b1;
      start_base = starts;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Called in the cycle after accept; checks latency, result, tag and start count.
   task automatic wait_and_check(input string name, input logic [1:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] tag, input int hold);
      logic [63:0] exp;
      int          lat = 1;
      bit          zero;
      exp  = exp_result(op, word, a, b);
      zero = exp_zero(word, b);
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_valid"}, resp_valid, 1);
      check({name, "_lat"}, lat, zero ? 1 : LAT_DIV);
      check({name, "_data"}, resp_data, exp);
      check({name, "_tag"}, resp_tag, tag);
      check({name, "_starts"}, starts - start_base, zero ? 0 : 1);
      check({name, "_busy_ready"}, req_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "_hold_valid"}, resp_valid, 1);
         check({name, "_hold_data"}, resp_data, exp);
         check({name, "_hold_tag"}, resp_tag, tag);
      end
   endtask

   task automatic handshake(input string name);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({name, "_drop"}, resp_valid, 0);
      check({name, "_ready"}, req_ready, 1);
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag, input int hold);
      send(op, word, a, b, tag);
      wait_and_check(name, op, word, a, b, tag, hold);
      handshake(name);
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      check({name, "_no_resp"}, seen, 0);
   endtask

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] NEG1  = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_div_start", div_start, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_tag", resp_tag, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", req_ready, 1);

      // directed operations
      run_op("div64",     2'd0, 1'b0, -64'sd7, 64'd2, 6'd5, 0);
      run_op("rem64",     2'd2, 1'b0, -64'sd7, 64'd2, 6'd6, 10);
      run_op("divu_w",    2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 6'd7, 0);
      run_op("remu_w",    2'd3, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 6'd8, 1);
      run_op("div_zero",  2'd0, 1'b0, -64'sd5, 64'd0, 6'd9, 0);
      run_op("rem_w_zero",2'd2, 1'b1, 64'h1_8000_0000, 64'hF_0000_0000, 6'd10, 2);
      run_op("div_ovf",   2'd0, 1'b0, MIN64, NEG1, 6'd11, 0);
      run_op("rem_ovf",   2'd2, 1'b0, MIN64, NEG1, 6'd12, 0);
      run_op("div_w_ovf", 2'd0, 1'b1, 64'hABCD_0000_8000_0000, 64'h1234_5678_FFFF_FFFF, 6'd13, 0);

      // backpressure, then handshake with the next request already waiting
      send(2'd1, 1'b0, 64'd1000, 64'd7, 6'd20);
      wait_and_check("bp", 2'd1, 1'b0, 64'd1000, 64'd7, 6'd20, 10);
      req_op = 2'd3; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd7; req_tag = 6'd21;
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("b2b_drop", resp_valid, 0);
      check("b2b_ready", req_ready, 1);
      start_base = starts;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_and_check("b2b", 2'd3, 1'b0, 64'd1000, 64'd7, 6'd21, 0);
      handshake("b2b");

      // flush while in ISSUE: start pulse suppressed, nothing returned
      send(2'd0, 1'b0, 64'd100, 64'd3, 6'd30);
      flush = 1'b1;
      #1;
      check("fl_issue_start", div_start, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("fl_issue_ready", req_ready, 1);
      expect_quiet("fl_issue", 80);
      check("fl_issue_starts", starts - start_base, 0);

      // flush at T+30, new request in T+31
      send(2'd0, 1'b0, 64'd999, 64'd4, 6'd31);
      repeat (29) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("fl30_ready", req_ready, 1);
      check("fl30_valid", resp_valid, 0);
      run_op("fl30_next", 2'd2, 1'b0, -64'sd1001, 64'd10, 6'd32, 0);

      // flush coincident with a DONE handshake
      send(2'd0, 1'b0, -64'sd5, 64'd0, 6'd33);
      check("fl_done_valid", resp_valid, 1);
      resp_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      flush = 1'b0;
      check("fl_done_drop", resp_valid, 0);
      check("fl_done_ready", req_ready, 1);

      // reset mid-WAIT
      send(2'd1, 1'b0, 64'd12345, 64'd9, 6'd34);
      repeat (20) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rw_valid", resp_valid, 0);
      check("rw_ready", req_ready, 0);
      check("rw_data", resp_data, 0);
      check("rw_tag", resp_tag, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rw_idle", req_ready, 1);
      expect_quiet("rw", 80);

      // randomized operations
      for (int n = 0; n < 30; n++) begin
         logic [1:0]  op;
         logic        word;
         logic [63:0] a, b;
         int          kind;
         op   = 2'($urandom_range(0, 3));
         word = 1'($urandom_range(0, 1));
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         kind = $urandom_range(0, 7);
         case (kind)
            0: b = word ? {b[63:32], 32'd0} : 64'd0;
            1: b = NEG1;
            2: b = 64'($urandom_range(1, 17));
            3: begin a = word ? {a[63:32], 32'h8000_0000} : MIN64; b = NEG1; end
            default: ;
         endcase
         run_op("rand", op, word, a, b, 6'($urandom), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
